// File: rtl/butterfly_pipe_pkg.sv
// Shared FFT datapath definitions: scaling encodings, default widths and
// {real, imag} / {cos, sin} packing helpers.
`ifndef BUTTERFLY_PIPE_PKG_DEFS
`define BUTTERFLY_PIPE_PKG_DEFS
`define FFT_CPLX_PACK(re, im) {(re), (im)}
`define FFT_TW_PACK(c, s) {(c), (s)}
`endif

package butterfly_pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 16;

  // Encoding 3 is reserved and behaves like SCALE_TRUNC.
  typedef enum logic [1:0] {
    SCALE_NONE      = 2'd0,
    SCALE_TRUNC     = 2'd1,
    SCALE_RND       = 2'd2,
    SCALE_TRUNC_ALT = 2'd3
  } scale_e;

endpackage

// File: rtl/butterfly_pipe_cmult.sv
// Pipelined complex multiply P = W*B (or conj(W)*B) with round-half-up and
// saturation back to DATA_W. Pure data pipeline: no valid, no reset.
module butterfly_pipe_cmult
  import butterfly_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TW_W     = DEF_TW_W,
  parameter int MULT_LAT = 4
) (
  input  logic                clk,
  input  logic [2*DATA_W-1:0] b,
  input  logic [2*TW_W-1:0]   w,
  input  logic                inverse,
  output logic [2*DATA_W-1:0] p,
  output logic                sat
);

  localparam int PW   = DATA_W + TW_W;
  localparam int SW   = PW + 2;
  localparam int TAIL = (MULT_LAT > 1) ? MULT_LAT - 1 : 1;

  localparam logic signed [SW-1:0] RND    = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
  localparam logic signed [SW-1:0] SAT_HI = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] v);
    sx = {{2{v[PW-1]}}, v};
  endfunction

  // Returns {clamped, value}.
  function automatic logic [DATA_W:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = (x + RND) >>> (TW_W - 1);
    if (r > SAT_HI)      round_sat = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (r < SAT_LO) round_sat = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                 round_sat = {1'b0, r[DATA_W-1:0]};
  endfunction

  logic signed [PW-1:0] c_x, s_x, br_x, bi_x;
  logic signed [PW-1:0] cbr_c, sbi_c, cbi_c, sbr_c;

  assign c_x  = {{DATA_W{w[2*TW_W-1]}}, w[2*TW_W-1:TW_W]};
  assign s_x  = {{DATA_W{w[TW_W-1]}}, w[TW_W-1:0]};
  assign br_x = {{TW_W{b[2*DATA_W-1]}}, b[2*DATA_W-1:DATA_W]};
  assign bi_x = {{TW_W{b[DATA_W-1]}}, b[DATA_W-1:0]};

  // Products of a DATA_W and a TW_W signed value always fit in PW bits.
  assign cbr_c = c_x * br_x;
  assign sbi_c = s_x * bi_x;
  assign cbi_c = c_x * bi_x;
  assign sbr_c = s_x * br_x;

  logic signed [PW-1:0] cbr_m, sbi_m, cbi_m, sbr_m;
  logic                 inv_m;

  if (MULT_LAT > 1) begin : g_prod_reg
    always_ff @(posedge clk) begin
      cbr_m <= cbr_c;
      sbi_m <= sbi_c;
      cbi_m <= cbi_c;
      sbr_m <= sbr_c;
      inv_m <= inverse;
    end
  end else begin : g_prod_comb
    assign cbr_m = cbr_c;
    assign sbi_m = sbi_c;
    assign cbi_m = cbi_c;
    assign sbr_m = sbr_c;
    assign inv_m = inverse;
  end

  // Conjugation flips the sign of the s-terms, so s = -2^(TW_W-1) stays exact.
  logic signed [SW-1:0] pr_sum, pi_sum;
  always_comb begin
    pr_sum = sx(cbr_m) - sx(sbi_m);
    pi_sum = sx(cbi_m) + sx(sbr_m);
    if (inv_m) begin
      pr_sum = sx(cbr_m) + sx(sbi_m);
      pi_sum = sx(cbi_m) - sx(sbr_m);
    end
  end

  logic [DATA_W:0]   pr_res, pi_res;
  logic [2*DATA_W:0] res_c;

  assign pr_res = round_sat(pr_sum);
  assign pi_res = round_sat(pi_sum);
  assign res_c  = {pr_res[DATA_W] | pi_res[DATA_W], pr_res[DATA_W-1:0], pi_res[DATA_W-1:0]};

  logic [2*DATA_W:0] tail_q [TAIL];

  always_ff @(posedge clk) begin
    tail_q[0] <= res_c;
    for (int i = 1; i < TAIL; i++) tail_q[i] <= tail_q[i-1];
  end

  assign p   = tail_q[TAIL-1][2*DATA_W-1:0];
  assign sat = tail_q[TAIL-1][2*DATA_W];

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B with per-operand
// inverse/scaling control, saturation and a sticky overflow flag.
module butterfly_pipe
  import butterfly_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TW_W     = DEF_TW_W,
  parameter int MULT_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   twiddle,
  input  logic                inverse,
  input  logic [1:0]          scale_mode,
  input  logic                ovf_clr,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] out_a,
  output logic [2*DATA_W-1:0] out_b,
  output logic                ovf
);

  localparam int LAT = MULT_LAT + 2;

  // Valid-only stream: no ready. An operand is taken on every clock edge with
  // in_valid=1; out_valid rises exactly LAT edges later, bubbles preserved.
  logic [LAT-1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= {vld_q[LAT-2:0], in_valid};
  end

  logic [2*DATA_W-1:0] p;
  logic                m_sat;

  butterfly_pipe_cmult #(
    .DATA_W   (DATA_W),
    .TW_W     (TW_W),
    .MULT_LAT (MULT_LAT)
  ) u_cmult (
    .clk     (clk),
    .b       (in_b),
    .w       (twiddle),
    .inverse (inverse),
    .p       (p),
    .sat     (m_sat)
  );

  // Operand A and scale mode ride alongside the multiplier, stage-gated.
  logic [2*DATA_W-1:0] a_q   [MULT_LAT];
  logic [1:0]          scl_q [MULT_LAT];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      a_q[0]   <= in_a;
      scl_q[0] <= scale_mode;
    end
    for (int i = 1; i < MULT_LAT; i++) begin
      if (vld_q[i-1]) begin
        a_q[i]   <= a_q[i-1];
        scl_q[i] <= scl_q[i-1];
      end
    end
  end

  function automatic logic [DATA_W:0] wext(input logic [DATA_W-1:0] v);
    wext = {v[DATA_W-1], v};
  endfunction

  logic [DATA_W-1:0] a_re, a_im, p_re, p_im;
  assign a_re = a_q[MULT_LAT-1][2*DATA_W-1:DATA_W];
  assign a_im = a_q[MULT_LAT-1][DATA_W-1:0];
  assign p_re = p[2*DATA_W-1:DATA_W];
  assign p_im = p[DATA_W-1:0];

  logic [DATA_W:0] sum_re_q, sum_im_q, dif_re_q, dif_im_q;
  logic [1:0]      scl_s_q;
  logic            msat_q;

  always_ff @(posedge clk) begin
    if (vld_q[MULT_LAT-1]) begin
      sum_re_q <= wext(a_re) + wext(p_re);
      sum_im_q <= wext(a_im) + wext(p_im);
      dif_re_q <= wext(a_re) - wext(p_re);
      dif_im_q <= wext(a_im) - wext(p_im);
      scl_s_q  <= scl_q[MULT_LAT-1];
      msat_q   <= m_sat;
    end
  end

  // Returns {clamped, value}; the halving modes always fit in DATA_W.
  function automatic logic [DATA_W:0] scale_sat(input logic [DATA_W:0] x,
                                                input logic [1:0]    m);
    logic [DATA_W+1:0] xr;
    xr = {x[DATA_W], x} + {{(DATA_W+1){1'b0}}, 1'b1};
    case (scale_e'(m))
      SCALE_NONE: begin
        if (x[DATA_W] != x[DATA_W-1])
          scale_sat = {1'b1, x[DATA_W], {(DATA_W-1){~x[DATA_W]}}};
        else
          scale_sat = {1'b0, x[DATA_W-1:0]};
      end
      SCALE_RND: scale_sat = {1'b0, xr[DATA_W:1]};
      default:   scale_sat = {1'b0, x[DATA_W:1]};
    endcase
  endfunction

  logic [DATA_W:0] o_ar, o_ai, o_br, o_bi;
  logic            clamp;

  assign o_ar  = scale_sat(sum_re_q, scl_s_q);
  assign o_ai  = scale_sat(sum_im_q, scl_s_q);
  assign o_br  = scale_sat(dif_re_q, scl_s_q);
  assign o_bi  = scale_sat(dif_im_q, scl_s_q);
  assign clamp = msat_q | o_ar[DATA_W] | o_ai[DATA_W] | o_br[DATA_W] | o_bi[DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= '0;
      out_b <= '0;
      ovf   <= 1'b0;
    end else begin
      if (vld_q[MULT_LAT]) begin
        out_a <= `FFT_CPLX_PACK(o_ar[DATA_W-1:0], o_ai[DATA_W-1:0]);
        out_b <= `FFT_CPLX_PACK(o_br[DATA_W-1:0], o_bi[DATA_W-1:0]);
      end
      // A fresh clamp takes priority over a simultaneous clear.
      if (vld_q[MULT_LAT] && clamp) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  assign out_valid = vld_q[LAT-1];

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised radix-2 DIT butterfly for the streaming FFT datapath, successor to the fixed 16-bit butterfly. Computes A' = A + W·B and B' = A − W·B with generic data/twiddle widths, forward/inverse mode, selectable per-stage scaling with optional rounding, saturation with a sticky overflow flag, and a valid pipeline so the stage controller can issue operands with bubbles. Sits between the FFT RAM read ports and write ports; the controller keys RAM writes off out_valid.

Parameters:
DATA_W, 16, width of each real/imag component of data (total complex word 2*DATA_W, packed {real, imag})
TW_W, 16, width of each twiddle component, signed Q1.(TW_W-1), packed {cos, sin}
MULT_LAT, 4, pipeline depth of the complex multiplier sub-module (>=1)
LAT, MULT_LAT+2, total in_valid-to-out_valid latency (derived localparam, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands on in_a/in_b/twiddle/mode inputs are valid this cycle
in_a  in  2*DATA_W  operand A {real, imag}, signed
in_b  in  2*DATA_W  operand B {real, imag}, signed
twiddle  in  2*TW_W  W = {cos, sin}, signed
inverse  in  1  1 = use conj(W) (IFFT)
scale_mode  in  2  0 none, 1 >>1 truncate, 2 >>1 round-half-up, 3 treated as 1
ovf_clr  in  1  clears sticky overflow flag
out_valid  out  1  out_a/out_b valid
out_a  out  2*DATA_W  A + W·B after scaling/saturation
out_b  out  2*DATA_W  A − W·B after scaling/saturation
ovf  out  1  sticky: any saturation since reset/clear

Behaviour:
- Reset (rst_n low, async): valid pipeline, out_valid, out_a, out_b, ovf all 0. Reset mid-stream discards all in-flight operands; no out_valid until LAT cycles after the first post-reset in_valid.
- No backpressure; one operand pair accepted every cycle in_valid=1. out_valid follows in_valid exactly LAT cycles later, bubbles preserved. Data registers update only when the corresponding stage is valid; out_a/out_b hold when out_valid=0.
- inverse and scale_mode are sampled with in_valid and travel with the operands; changing them between consecutive operands is legal.
- Multiply (MULT_LAT cycles): forward Pr = c·br − s·bi, Pi = c·bi + s·br; inverse Pr = c·br + s·bi, Pi = c·bi − s·br. Full-precision products/sums, then +2^(TW_W-2) and arithmetic >> (TW_W-1) (round-half-up), then saturate to DATA_W bits. Conjugation done on the product sign, never by negating s (s = −2^(TW_W-1) is legal).
- in_a delayed MULT_LAT cycles to align with P.
- Add stage (1 cycle): sums/differences in DATA_W+1 bits: Ar±Pr, Ai±Pi.
- Output stage (1 cycle): mode 0: saturate to DATA_W; mode 1: arithmetic >>1; mode 2: (x+1)>>>1. Modes 1/2 cannot overflow.
- Saturation: clamp to +(2^(DATA_W-1)−1) / −2^(DATA_W-1). Any clamp (product or output) on a valid operand sets ovf at output stage. ovf_clr clears ovf; a clamp in the same cycle as ovf_clr wins (ovf stays 1).

Decomposition:
- Shared package/header fft_defs: scale_mode encodings (SCALE_NONE, SCALE_TRUNC, SCALE_RND), packing macros for {real,imag} and {cos,sin}, default DATA_W/TW_W.
- Sub-module cmult_pipe (params DATA_W, TW_W, MULT_LAT): complex multiply with inverse control, rounding, saturation, per-operand sat flag, pure pipeline (no valid logic, no reset on data regs). Butterfly owns valid/mode pipeline, alignment delay, add/scale/saturate stages.

Test Plan:
- DATA_W=TW_W=16, scale 0, fwd: A=(1000,−500), B=(200,300), W=(0x7FFF,0) -> 6 cycles later out_a=(1200,−200), out_b=(800,−800), ovf=0.
- W=(0,0x8000) (−j), fwd: same A,B -> out_a=(1300,−700), out_b=(700,−300); inverse=1 -> out_a=(700,−300), out_b=(1300,−700); no ovf.
- A=(32000,0), B=(32000,0), W=(0x7FFF,0): mode 0 -> out_a=(32767,0), out_b=(1,0), ovf=1; mode 1 -> (31999,0)/(0,0); mode 2 -> (32000,0)/(1,0).
- in_valid pattern 1,0,1,1,0,1 with distinct operands -> out_valid identical pattern delayed 6 cycles, results in order, held during bubbles.
- ovf_clr pulse with no saturating traffic -> ovf 0 next cycle; ovf_clr coinciding with a saturating result -> ovf stays 1.
- Assert rst_n low for one cycle with 3 operands in flight -> outputs and ovf 0 immediately (async), no out_valid for those operands; next operand emerges exactly LAT cycles after issue.
